// File: rtl/cvi_stream_rx_pkg.sv
// Shared types for the clocked-video to Avalon-ST receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cvi_stream_rx_pkg;

    localparam int         RX_DATA_W      = 24;
    localparam int         CNT_W          = 12;
    localparam logic [3:0] HDR_TYPE_VIDEO = 4'h0;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_DROP      = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [RX_DATA_W-1:0] data;
        logic                 sop;
        logic                 eop;
    } rx_entry_t;

endpackage

// File: rtl/cvi_rx_fifo.sv
// Show-ahead FIFO for the receiver output beats.
// Latency: 1 cycle push to rd_vld; head visible combinationally.
// Backpressure: push refused while full (even with a pop); no empty bypass.
module cvi_rx_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld = (wr_ptr != rd_ptr);
    assign push   = wr_vld && !full;
    assign pop    = rd_vld && rd_rdy;
    // Head reads as zero when empty so the stream outputs are clean out of reset.
    assign rd_dat = rd_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/cvi_stream_rx.sv
// Clocked video (vsync + datavalid) to Avalon-ST video packets with frame stats.
// Latency: header on first pixel, each pixel emitted one pixel later (hold register) plus 1 FIFO cycle.
// Backpressure: source_ready pops the FIFO; a write into a full FIFO drops the rest of the frame and flags overflow.
module cvi_stream_rx
    import cvi_stream_rx_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] vid_data,
    input  logic              vid_datavalid,
    input  logic              vid_v_sync,
    input  logic              vid_h_sync,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    output logic              source_startofpacket,
    output logic              source_endofpacket,
    input  logic              source_ready,
    output logic              overflow,
    output logic [15:0]       frame_count,
    output logic [11:0]       last_width,
    output logic [11:0]       last_height
);

    rx_state_t          state_q, state_d;
    logic               vs_q, dv_q;
    logic               vs_rise, dv_fall;
    logic [DATA_W-1:0]  hold_q;
    logic               pend_q;
    logic [CNT_W-1:0]   wcnt_q, lcnt_q, wcnt_nx, lcnt_nx;
    logic               wdone_q;
    logic               push_vld, fifo_full;
    rx_entry_t          push_ent, head_ent;
    logic               hold_ld, cnt_clr, frame_done, ovf_set, pend_set, pend_clr;
    logic               unused_h_sync;

    assign unused_h_sync = vid_h_sync;
    assign vs_rise       = vid_v_sync && !vs_q;
    assign dv_fall       = dv_q && !vid_datavalid;

    // Width stops at the first line end; a pixel coinciding with vsync is never counted.
    assign wcnt_nx = (vid_datavalid && !vs_rise && !wdone_q && wcnt_q != '1) ? wcnt_q + 1'b1 : wcnt_q;
    assign lcnt_nx = (dv_fall && lcnt_q != '1) ? lcnt_q + 1'b1 : lcnt_q;

    always_comb begin
        state_d    = state_q;
        push_vld   = 1'b0;
        push_ent   = '0;
        hold_ld    = 1'b0;
        cnt_clr    = 1'b0;
        frame_done = 1'b0;
        ovf_set    = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        case (state_q)
            ST_WAIT_SYNC: if (vs_rise) state_d = ST_IDLE;
            ST_IDLE: if (vid_datavalid && !vs_rise) begin
                push_vld      = 1'b1;
                push_ent.data = {{(DATA_W-4){1'b0}}, HDR_TYPE_VIDEO};
                push_ent.sop  = 1'b1;
                if (fifo_full) begin
                    ovf_set  = 1'b1;
                    pend_set = 1'b1;
                    state_d  = ST_DROP;
                end else begin
                    hold_ld = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: if (vs_rise) begin
                push_vld      = 1'b1;
                push_ent.data = hold_q;
                push_ent.eop  = 1'b1;
                if (fifo_full) begin
                    ovf_set  = 1'b1;
                    pend_set = 1'b1;
                    state_d  = ST_DROP;
                end else begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end else if (vid_datavalid) begin
                push_vld      = 1'b1;
                push_ent.data = hold_q;
                if (fifo_full) begin
                    ovf_set  = 1'b1;
                    pend_set = 1'b1;
                    state_d  = ST_DROP;
                end else begin
                    hold_ld = 1'b1;
                end
            end
            ST_DROP: if (pend_q && !fifo_full) begin
                push_vld      = 1'b1;
                push_ent.data = hold_q;
                push_ent.eop  = 1'b1;
                pend_clr      = 1'b1;
            end else if (!pend_q && vs_rise) begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_SYNC;
            vs_q        <= 1'b0;
            dv_q        <= 1'b0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            wcnt_q      <= '0;
            lcnt_q      <= '0;
            wdone_q     <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
            last_width  <= '0;
            last_height <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= vid_v_sync;
            dv_q    <= vid_datavalid;
            if (hold_ld) hold_q <= vid_data;
            if (ovf_set) overflow <= 1'b1;
            if (pend_set)      pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;
            // The pixel that opens the packet counts as the first pixel of the first line.
            if (cnt_clr) begin
                wcnt_q  <= CNT_W'(1);
                lcnt_q  <= '0;
                wdone_q <= 1'b0;
            end else if (state_q == ST_ACTIVE) begin
                wcnt_q <= wcnt_nx;
                lcnt_q <= lcnt_nx;
                if (dv_fall) wdone_q <= 1'b1;
            end
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
                last_width  <= wcnt_nx;
                last_height <= lcnt_nx;
            end
        end
    end

    cvi_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (push_vld),
        .wr_dat  (push_ent),
        .full    (fifo_full),
        .rd_vld  (source_valid),
        .rd_dat  (head_ent),
        .rd_rdy  (source_ready)
    );

    assign source_data          = head_ent.data;
    assign source_startofpacket = head_ent.sop;
    assign source_endofpacket   = head_ent.eop;

endmodule

// File: tb/tb_cvi_stream_rx.sv
// Bench for cvi_stream_rx: frame-shape table, hand-written corner sequences, random backpressure.
module tb_cvi_stream_rx;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;
    localparam int GAP    = 6;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    typedef struct {
        int w;
        int h;
        int exp_w;
        int exp_h;
        int exp_beats;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] vid_data = '0;
    logic              vid_datavalid = 1'b0;
    logic              vid_v_sync = 1'b0;
    logic              vid_h_sync = 1'b0;
    logic [DATA_W-1:0] source_data;
    logic              source_valid;
    logic              source_startofpacket;
    logic              source_endofpacket;
    logic              source_ready = 1'b1;
    logic              overflow;
    logic [15:0]       frame_count;
    logic [11:0]       last_width;
    logic [11:0]       last_height;

    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    int    exp_frames = 0;
    int    ready_mode = 1;
    beat_t exp_q[$];
    vec_t  vecs[6];

    cvi_stream_rx #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .vid_data             (vid_data),
        .vid_datavalid        (vid_datavalid),
        .vid_v_sync           (vid_v_sync),
        .vid_h_sync           (vid_h_sync),
        .source_data          (source_data),
        .source_valid         (source_valid),
        .source_startofpacket (source_startofpacket),
        .source_endofpacket   (source_endofpacket),
        .source_ready         (source_ready),
        .overflow             (overflow),
        .frame_count          (frame_count),
        .last_width           (last_width),
        .last_height          (last_height)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [DATA_W-1:0] d, input logic sop, input logic eop);
        exp_q.push_back({d, sop, eop});
    endtask

    task automatic set_ready(input int m);
        ready_mode   = m;
        source_ready = (m == 1) ? 1'b1 : (m == 2) ? ($urandom_range(3, 0) != 0) : 1'b0;
    endtask

    // One clock: score any accepted beat at the falling edge, then move ready after the rising edge.
    task automatic step();
        beat_t got, want;
        @(negedge clk);
        if (reset_n && source_valid && source_ready) begin
            got = {source_data, source_startofpacket, source_endofpacket};
            beats_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data=%h sop=%0d eop=%0d, expected no beat",
                         got.data, got.sop, got.eop);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL beat: got data=%h sop=%0d eop=%0d, expected data=%h sop=%0d eop=%0d",
                             got.data, got.sop, got.eop, want.data, want.sop, want.eop);
                end
            end
        end
        @(posedge clk);
        #1;
        if (ready_mode == 2) source_ready = ($urandom_range(3, 0) != 0);
    endtask

    task automatic vsync_pulse();
        vid_v_sync = 1'b1;
        repeat (2) step();
        vid_v_sync = 1'b0;
        repeat (2) step();
    endtask

    // Model: header, then every pixel in raster order, eop on the final pixel of the frame.
    task automatic send_lines(input int w, input int h);
        logic [DATA_W-1:0] px;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                px = DATA_W'($urandom);
                if (x == 0 && y == 0) exp_push('0, 1'b1, 1'b0);
                exp_push(px, 1'b0, (x == w - 1) && (y == h - 1));
                vid_data      = px;
                vid_datavalid = 1'b1;
                step();
            end
            vid_datavalid = 1'b0;
            vid_h_sync    = 1'b1;
            step();
            vid_h_sync = 1'b0;
            repeat (GAP) step();
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        logic [DATA_W-1:0] pix[20];

        vecs[0] = '{4, 2, 4, 2, 9};
        vecs[1] = '{1, 1, 1, 1, 2};
        vecs[2] = '{8, 4, 8, 4, 33};
        vecs[3] = '{3, 5, 3, 5, 16};
        vecs[4] = '{12, 1, 12, 1, 13};
        vecs[5] = '{4100, 1, 4095, 1, 4101};

        repeat (3) step();
        chk("rst_valid", source_valid, 0);
        chk("rst_sop", source_startofpacket, 0);
        chk("rst_eop", source_endofpacket, 0);
        chk("rst_data", source_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_last_width", last_width, 0);
        chk("rst_last_height", last_height, 0);
        reset_n = 1'b1;
        set_ready(1);

        // Pixels before any vsync must be discarded.
        for (int i = 0; i < 10; i++) begin
            vid_data      = DATA_W'($urandom);
            vid_datavalid = (i % 5) != 4;
            step();
        end
        vid_datavalid = 1'b0;
        repeat (4) step();
        chk("presync_valid", source_valid, 0);

        vsync_pulse();
        for (int i = 0; i < 6; i++) begin
            b0 = beats_seen;
            send_lines(vecs[i].w, vecs[i].h);
            vsync_pulse();
            exp_frames++;
            drain(200);
            chk($sformatf("frame_count[%0d]", i), frame_count, exp_frames);
            chk($sformatf("last_width[%0d]", i), last_width, vecs[i].exp_w);
            chk($sformatf("last_height[%0d]", i), last_height, vecs[i].exp_h);
            chk($sformatf("beats[%0d]", i), beats_seen - b0, vecs[i].exp_beats);
        end

        // Pixel coincident with the closing vsync edge is dropped.
        send_lines(3, 1);
        vid_data      = DATA_W'($urandom);
        vid_datavalid = 1'b1;
        vid_v_sync    = 1'b1;
        step();
        vid_datavalid = 1'b0;
        step();
        vid_v_sync = 1'b0;
        repeat (2) step();
        exp_frames++;
        drain(100);
        chk("coinc_frame_count", frame_count, exp_frames);
        chk("coinc_last_width", last_width, 3);
        chk("coinc_overflow", overflow, 0);

        // Overflow: a 20-pixel line into a stalled FIFO of DEPTH entries.
        set_ready(0);
        for (int i = 0; i < 20; i++) begin
            pix[i]        = DATA_W'($urandom);
            vid_data      = pix[i];
            vid_datavalid = 1'b1;
            step();
        end
        vid_datavalid = 1'b0;
        repeat (4) step();
        chk("ovf_set", overflow, 1);
        exp_push('0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) exp_push(pix[i], 1'b0, 1'b0);
        exp_push(pix[DEPTH-1], 1'b0, 1'b1);
        b0 = beats_seen;
        set_ready(1);
        drain(100);
        chk("ovf_beats", beats_seen - b0, DEPTH + 1);
        vsync_pulse();
        chk("ovf_frame_count", frame_count, exp_frames);

        // Reset in the middle of a frame with beats waiting in the FIFO.
        set_ready(0);
        for (int i = 0; i < 5; i++) begin
            vid_data      = DATA_W'($urandom);
            vid_datavalid = 1'b1;
            step();
        end
        vid_datavalid = 1'b0;
        step();
        chk("prereset_valid", source_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", source_valid, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_frame_count", frame_count, 0);
        exp_q.delete();
        exp_frames = 0;
        repeat (2) step();
        reset_n = 1'b1;
        set_ready(1);
        for (int i = 0; i < 4; i++) begin
            vid_data      = DATA_W'($urandom);
            vid_datavalid = 1'b1;
            step();
        end
        vid_datavalid = 1'b0;
        repeat (3) step();
        chk("postrst_valid", source_valid, 0);
        vsync_pulse();
        send_lines(2, 2);
        vsync_pulse();
        exp_frames++;
        drain(100);
        chk("postrst_frame_count", frame_count, exp_frames);
        chk("postrst_last_height", last_height, 2);

        // Random backpressure over three 8x4 frames.
        set_ready(2);
        b0 = beats_seen;
        for (int f = 0; f < 3; f++) begin
            send_lines(8, 4);
            vsync_pulse();
            exp_frames++;
        end
        drain(1000);
        chk("rand_beats", beats_seen - b0, 3 * 33);
        chk("rand_overflow", overflow, 0);
        chk("rand_frame_count", frame_count, exp_frames);
        chk("rand_last_width", last_width, 8);
        chk("rand_last_height", last_height, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
